// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen_if
// Purpose  : Raster timing bundle between the timing generator and its consumers.
// Revision : 1.0
// ============================================================================
interface video_timing_gen_if #(
  parameter int CW = 12
);
  logic          i_en;
  logic          o_req;
  logic          o_de;
  logic          o_hsync;
  logic          o_vsync;
  logic [1:0]    o_ctrl;
  logic [CW-1:0] o_sx;
  logic [CW-1:0] o_sy;
  logic          o_line;
  logic          o_frame;

  modport master (
    input  i_en,
    output o_req, o_de, o_hsync, o_vsync, o_ctrl, o_sx, o_sy, o_line, o_frame
  );

  modport slave (
    output i_en,
    input  o_req, o_de, o_hsync, o_vsync, o_ctrl, o_sx, o_sy, o_line, o_frame
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Raster timing for DVI TMDS encoders: de, sync/ctrl, coordinates.
// Revision : 1.0
// ============================================================================
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 12
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  video_timing_gen_if.master vif
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] c_h_last = CW'(c_h_total - 1);
  localparam logic [CW-1:0] c_v_last = CW'(c_v_total - 1);

  // One bit wider so a region end equal to the total cannot alias to zero.
  localparam logic [CW:0] c_h_active   = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] c_hs_start   = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] c_hs_end     = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] c_v_active   = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] c_vs_start   = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] c_vs_end     = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (((c_h_total - 1) >= (1 << CW)) || ((c_v_total - 1) >= (1 << CW))) begin : g_cw_check
    $error("video_timing_gen: CW too narrow for raster totals");
  end

  logic [CW-1:0] hx_q, hx_d;
  logic [CW-1:0] vy_q, vy_d;
  logic [CW-1:0] sx_q, sy_q;
  logic          de_q, hs_q, vs_q, line_q, frame_q;

  logic          w_h_wrap, w_v_wrap;
  logic          w_req, w_hs_act, w_vs_act;
  logic [CW:0]   w_hx_ext, w_vy_ext;

  always_comb begin
    w_hx_ext = {1'b0, hx_q};
    w_vy_ext = {1'b0, vy_q};
    w_h_wrap = (hx_q == c_h_last);
    w_v_wrap = (vy_q == c_v_last);

    hx_d = w_h_wrap ? '0 : hx_q + CW'(1);
    vy_d = vy_q;
    if (w_h_wrap) begin
      vy_d = w_v_wrap ? '0 : vy_q + CW'(1);
    end

    w_req    = (w_hx_ext < c_h_active) && (w_vy_ext < c_v_active);
    w_hs_act = (w_hx_ext >= c_hs_start) && (w_hx_ext < c_hs_end);
    // vsync is a whole-line property, so it changes only at hx==0.
    w_vs_act = (w_vy_ext >= c_vs_start) && (w_vy_ext < c_vs_end);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hx_q    <= '0;
      vy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (vif.i_en) begin
      hx_q    <= hx_d;
      vy_q    <= vy_d;
      sx_q    <= hx_q;
      sy_q    <= vy_q;
      de_q    <= w_req;
      hs_q    <= w_hs_act ? H_POL : ~H_POL;
      vs_q    <= w_vs_act ? V_POL : ~V_POL;
      line_q  <= (hx_q == '0);
      frame_q <= (hx_q == '0) && (vy_q == '0);
    end
  end

  assign vif.o_req   = w_req;
  assign vif.o_de    = de_q;
  assign vif.o_hsync = hs_q;
  assign vif.o_vsync = vs_q;
  assign vif.o_ctrl  = {vs_q, hs_q};
  assign vif.o_sx    = sx_q;
  assign vif.o_sy    = sy_q;
  assign vif.o_line  = line_q;
  assign vif.o_frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Directed self-checking bench for video_timing_gen (wide and tiny rasters).
// Revision : 1.0
// ============================================================================
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_w;
  logic rst_s;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(12)) wif ();
  video_timing_gen_if #(.CW(4))  sif ();

  // Default horizontal timing, shortened vertical: 4 active, sync on lines 5..6.
  video_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(12)
  ) u_wide (
    .i_clk (clk),
    .i_rst (rst_w),
    .vif   (wif.master)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4)
  ) u_small (
    .i_clk (clk),
    .i_rst (rst_s),
    .vif   (sif.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected tiny-raster outputs after k enabled edges since reset (7x5 raster).
  function automatic logic [14:0] exp_small(input int k);
    int x, y;
    logic de, hs, vs;
    if (k == 0) return 15'd0;
    x  = (k - 1) % 7;
    y  = ((k - 1) / 7) % 5;
    de = (x < 4) && (y < 2);
    hs = (x == 5);
    vs = (y == 3);
    return {de, hs, vs, vs, hs, 4'(x), 4'(y), (x == 0), (x == 0) && (y == 0)};
  endfunction

  int   e_de, e_hs, e_vs, e_line, e_lsp, e_req, e_cnt, e_vedge;
  int   n_de, n_hs_low, n_vs_low, n_lines, n_frames, n_vedge;
  int   last_line, first_frame, frame_gap;
  int   prev_sx, prev_sy, k, e_s, e_sreq, e_freeze, n_low;
  logic prev_req, prev_vs, en_now, found;
  logic [14:0] got, got_prev, exp_v, exp_n;
  logic pat [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_w = 1'b1;
    rst_s = 1'b1;
    wif.i_en = 1'b1;
    sif.i_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check_eq("w_rst_req",   wif.o_req,   1);
    check_eq("w_rst_de",    wif.o_de,    0);
    check_eq("w_rst_ctrl",  wif.o_ctrl,  3);
    check_eq("w_rst_sx",    wif.o_sx,    0);
    check_eq("w_rst_sy",    wif.o_sy,    0);
    check_eq("w_rst_line",  wif.o_line,  0);
    check_eq("w_rst_frame", wif.o_frame, 0);
    check_eq("s_rst_ctrl",  sif.o_ctrl,  0);
    check_eq("s_rst_req",   sif.o_req,   1);

    // ---------------- wide raster: one full frame plus the next (0,0) ----------
    rst_w = 1'b0;
    {e_de, e_hs, e_vs, e_line, e_lsp, e_req, e_cnt, e_vedge} = '0;
    {n_de, n_hs_low, n_vs_low, n_lines, n_frames, n_vedge}   = '0;
    last_line = -1; first_frame = -1; frame_gap = -1;
    prev_sx = 0; prev_sy = 0; prev_req = 1'b0; prev_vs = 1'b1;
    for (int c = 0; c < 6401; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        check_eq("w_first_de",    wif.o_de,    1);
        check_eq("w_first_frame", wif.o_frame, 1);
        check_eq("w_first_line",  wif.o_line,  1);
        check_eq("w_first_sx",    wif.o_sx,    0);
      end
      if (wif.o_de !== ((wif.o_sx < 640) && (wif.o_sy < 4))) e_de++;
      if (wif.o_de) n_de++;
      if (wif.o_hsync !== !((wif.o_sx >= 656) && (wif.o_sx < 752)) ||
          wif.o_ctrl[0] !== wif.o_hsync) e_hs++;
      if (!wif.o_hsync) n_hs_low++;
      if (wif.o_vsync !== !((wif.o_sy >= 5) && (wif.o_sy < 7)) ||
          wif.o_ctrl[1] !== wif.o_vsync) e_vs++;
      if (!wif.o_vsync) n_vs_low++;
      if (wif.o_line !== (wif.o_sx == 0)) e_line++;
      if (wif.o_line) begin
        if (last_line >= 0 && (c - last_line) != 800) e_lsp++;
        last_line = c;
        n_lines++;
      end
      if (wif.o_frame) begin
        if (first_frame < 0) first_frame = c;
        else frame_gap = c - first_frame;
        n_frames++;
      end
      if (c > 0) begin
        if (wif.o_de !== prev_req) e_req++;
        if (int'(wif.o_sx) != ((prev_sx == 799) ? 0 : prev_sx + 1)) e_cnt++;
        if (int'(wif.o_sy) != ((prev_sx == 799) ? ((prev_sy == 7) ? 0 : prev_sy + 1) : prev_sy)) e_cnt++;
        if (wif.o_vsync !== prev_vs) begin
          n_vedge++;
          if (!wif.o_line || wif.o_sx != 0) e_vedge++;
        end
      end
      prev_req = wif.o_req;
      prev_sx  = int'(wif.o_sx);
      prev_sy  = int'(wif.o_sy);
      prev_vs  = wif.o_vsync;
    end
    // The last sample is (0,0) of the following frame.
    check_eq("w_de_region",   e_de,      0);
    check_eq("w_de_count",    n_de,      2561);
    check_eq("w_hsync_place", e_hs,      0);
    check_eq("w_hsync_low",   n_hs_low,  768);
    check_eq("w_vsync_place", e_vs,      0);
    check_eq("w_vsync_low",   n_vs_low,  1600);
    check_eq("w_line_pos",    e_line,    0);
    check_eq("w_line_period", e_lsp,     0);
    check_eq("w_line_count",  n_lines,   9);
    check_eq("w_frame_count", n_frames,  2);
    check_eq("w_frame_gap",   frame_gap, 6400);
    check_eq("w_req_lead",    e_req,     0);
    check_eq("w_coord_seq",   e_cnt,     0);
    check_eq("w_vsync_edges", n_vedge,   2);
    check_eq("w_vsync_align", e_vedge,   0);

    // ---------------- tiny raster: free run, then enable pattern 1,0,0,1 -------
    rst_s = 1'b0;
    k = 0; e_s = 0; e_sreq = 0; e_freeze = 0; n_low = 0;
    got_prev = sif.o_de ? 15'h7fff : 15'd0;
    for (int c = 0; c < 100; c++) begin
      en_now   = (c < 40) ? 1'b1 : pat[(c - 40) % 4];
      sif.i_en = en_now;
      @(posedge clk);
      #1;
      if (en_now) k++;
      got   = {sif.o_de, sif.o_hsync, sif.o_vsync, sif.o_ctrl,
               sif.o_sx, sif.o_sy, sif.o_line, sif.o_frame};
      exp_v = exp_small(k);
      exp_n = exp_small(k + 1);
      if (got !== exp_v) e_s++;
      if (sif.o_req !== exp_n[14]) e_sreq++;
      if (!en_now) begin
        n_low++;
        if (got !== got_prev) e_freeze++;
      end
      got_prev = got;
      case (c)
        0: begin
          check_eq("s_first_frame", sif.o_frame, 1);
          check_eq("s_first_de",    sif.o_de,    1);
        end
        5:  check_eq("s_hsync_at5",  sif.o_hsync, 1);
        6:  check_eq("s_sx_max",     sif.o_sx,    6);
        7: begin
          check_eq("s_sx_wrap",    sif.o_sx,   0);
          check_eq("s_sy_step",    sif.o_sy,   1);
          check_eq("s_line_wrap",  sif.o_line, 1);
        end
        34: check_eq("s_sy_max",     sif.o_sy,    4);
        35: begin
          check_eq("s_sy_wrap",    sif.o_sy,    0);
          check_eq("s_frame_wrap", sif.o_frame, 1);
        end
        default: ;
      endcase
    end
    check_eq("s_sequence",  e_s,      0);
    check_eq("s_req_lead",  e_sreq,   0);
    check_eq("s_en_freeze", e_freeze, 0);
    check_eq("s_en_k",      k,        70);
    check_eq("s_en_lows",   n_low,    30);

    // ---------------- wide raster: asynchronous reset at (300,2) ---------------
    found = 1'b0;
    for (int c = 0; c < 10000 && !found; c++) begin
      @(posedge clk);
      #1;
      if (wif.o_sx == 300 && wif.o_sy == 2) found = 1'b1;
    end
    check_eq("w_mid_reach", found, 1);
    #2;
    rst_w = 1'b1;
    #1;
    check_eq("w_arst_de",    wif.o_de,    0);
    check_eq("w_arst_ctrl",  wif.o_ctrl,  3);
    check_eq("w_arst_sx",    wif.o_sx,    0);
    check_eq("w_arst_sy",    wif.o_sy,    0);
    check_eq("w_arst_line",  wif.o_line,  0);
    check_eq("w_arst_req",   wif.o_req,   1);
    @(posedge clk);
    #1;
    rst_w = 1'b0;
    @(posedge clk);
    #1;
    check_eq("w_rel_frame", wif.o_frame, 1);
    check_eq("w_rel_sx",    wif.o_sx,    0);
    check_eq("w_rel_sy",    wif.o_sy,    0);
    check_eq("w_rel_de",    wif.o_de,    1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator sitting directly upstream of the per-channel TMDS encoders in the DVI output path.
- Produces display enable, sync levels and 2-bit control words for the encoder inputs (de, ctrl), plus pixel coordinates and request strobes for the pixel source.
- Runs in the pixel clock domain; an optional clock enable allows operation from a faster clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active low)
- V_POL, 0, vsync active level (0 = active low)
- CW, 12, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active high
- i_en  in  1  pixel advance enable; when low, all state and outputs hold
- o_req  out  1  pixel request; high one enabled cycle before o_de for the same pixel
- o_de  out  1  display enable to encoder i_de
- o_hsync  out  1  horizontal sync level, polarity applied
- o_vsync  out  1  vertical sync level, polarity applied
- o_ctrl  out  2  {o_vsync, o_hsync}; drives the blue-channel encoder i_ctrl
- o_sx  out  CW  x coordinate of the pixel currently presented on o_de
- o_sy  out  CW  y coordinate of the pixel currently presented on o_de
- o_line  out  1  one-cycle pulse when o_sx==0 (every line)
- o_frame  out  1  one-cycle pulse when o_sx==0 and o_sy==0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal counters hx, vy.
  - On each i_en cycle hx increments.
  - At hx==H_TOTAL-1, hx wraps to 0 and vy increments.
  - At vy==V_TOTAL-1 together with hx wrap, vy wraps to 0.
- Raster order: active region first, then front porch, then sync, then back porch.
- o_req is combinational from the counters: (hx<H_ACTIVE) && (vy<V_ACTIVE).
- All other outputs are registered from the counter state on each i_en cycle, giving 1 enabled-cycle latency.
  - o_de = registered o_req.
  - o_sx, o_sy = registered hx, vy.
- hsync active when H_ACTIVE+H_FP <= hx < H_ACTIVE+H_FP+H_SYNC.
- vsync active for the whole lines V_ACTIVE+V_FP <= vy < V_ACTIVE+V_FP+V_SYNC. vsync edges therefore align with hx==0, not with hsync.
- Output level: o_hsync = active ? H_POL : ~H_POL. o_vsync uses V_POL the same way.
- o_ctrl is always {o_vsync, o_hsync}, including during o_de=1; the encoder ignores ctrl while de is high.
- o_line and o_frame are registered and coincide with the o_sx/o_sy they describe. Each lasts exactly one enabled cycle.
- Reset (async assert, counters released on next clock edge):
  - hx=0, vy=0, o_de=0.
  - o_hsync=~H_POL, o_vsync=~V_POL, so o_ctrl=2'b11 with defaults.
  - o_sx=0, o_sy=0, o_line=0, o_frame=0.
  - o_req goes high immediately, since (0,0) is active.
  - First enabled cycle after reset registers (0,0): o_de=1, o_frame=1, o_line=1.
- Reset mid-frame: all outputs return to their reset values within the asserting edge (asynchronous); the raster restarts at (0,0).
- i_en low: counters and every registered output hold their values. Pulses (o_line, o_frame) stretch for the duration of i_en low.
- Counter arithmetic is unsigned CW-bit; no other wrap condition exists.
- Widths must be elaborated so that H_TOTAL-1 fits in CW bits.

Test Plan:
- Defaults, i_en=1 after reset: o_de high for exactly 640 consecutive cycles per line and 480 lines per frame; the line period is 800 cycles and the frame period is 420000 cycles (o_frame pulse spacing).
- hsync placement (defaults): o_hsync low when o_sx is 656..751 inclusive, high otherwise; o_ctrl[0] tracks it.
- vsync placement (defaults): o_vsync low when o_sy is 490..491 for all o_sx 0..799; it transitions on the o_line pulse; o_ctrl[1] tracks it.
- Small params (H 4/1/1/1, V 2/1/1/1, H_POL=1, V_POL=1): o_sx wraps 6→0 and o_sy wraps 4→0; o_hsync is high only at o_sx==5; o_req leads o_de by exactly one cycle at every edge.
- i_en toggled 1,0,0,1 repeatedly: every output is frozen during the low cycles; the output sequence equals the i_en=1 sequence with repeats inserted.
- Assert i_rst at (o_sx=300, o_sy=200): outputs go to reset values without a clock edge; after release, the first enabled cycle gives o_frame=1, o_sx=0, o_sy=0, o_de=1.
